fifo_stream_reader: RTL and testbench

Drains a synchronous FIFO with a registered one-cycle read port (rd_en / r_data / empty) and presents its contents as a valid/ready stream with a packet-boundary flag. Sits directly downstream of the FIFO. Absorbs the FIFO read latency in a 3-entry output buffer, so back-to-back reads sustain one word per cycle while the consumer accepts. Every PKT_LEN-th delivered word is marked with m_last.

---
 rtl/fifo_stream_reader.sv | 100 ++++++++++
 tb/tb_fifo_stream_reader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream, flagging every PKT_LEN-th word with m_last.
// Define FIFO_READER_STATS_EN to add saturating stat_words / stat_stalls counters.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [31:0]           stat_words,
    output logic [31:0]           stat_stalls
`endif
);

    localparam int               CNT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] r_buf [3];
    logic [1:0]            r_head;
    logic [1:0]            r_tail;
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [CNT_W-1:0]      r_pkt_cnt;

    logic                  w_capture;
    logic                  w_pop;
    logic [2:0]            w_pending;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue is gated on flops and empty only, so m_ready never reaches rd_en.
    assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight};
    assign rd_en     = !rst && !empty && (w_pending < 3'd3);
    assign w_capture = r_inflight;
    assign m_valid   = (r_occ != 2'd0);
    assign w_pop     = m_valid && m_ready;
    assign m_data    = r_buf[r_head];
    assign m_last    = m_valid && (r_pkt_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_pkt_cnt  <= '0;
        end else begin
            // NOTE: non-blocking so each flop samples pre-edge values, independent of statement order.
            r_inflight <= rd_en;
            if (w_capture) r_tail <= ptr_inc(r_tail);
            if (w_pop)     r_head <= ptr_inc(r_head);
            case ({w_capture, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
            if (w_pop) r_pkt_cnt <= (r_pkt_cnt == CNT_MAX) ? '0 : r_pkt_cnt + 1'b1;
        end
    end

    // NOTE: the 3-entry buffer is reset so m_data reads 0 out of reset without gating on m_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) r_buf[i] <= '0;
        end else if (w_capture) begin
            r_buf[r_tail] <= r_data;
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [31:0] r_stat_words;
    logic [31:0] r_stat_stalls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_words  <= 32'd0;
            r_stat_stalls <= 32'd0;
        end else begin
            if (w_pop && (r_stat_words != 32'hFFFF_FFFF))
                r_stat_words <= r_stat_words + 32'd1;
            if (m_valid && !m_ready && (r_stat_stalls != 32'hFFFF_FFFF))
                r_stat_stalls <= r_stat_stalls + 32'd1;
        end
    end

    assign stat_words  = r_stat_words;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a depth-8 registered-read FIFO model feeds the DUT and a
// scoreboard of expected words/m_last is checked on every cycle m_valid is high.
module tb_fifo_stream_reader;

    localparam int DW      = 8;
    localparam int PKT_LEN = 4;

    logic          clk;
    logic          rst;
    logic          empty;
    logic          rd_en;
    logic [DW-1:0] r_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef FIFO_READER_STATS_EN
    logic [31:0]   stat_words;
    logic [31:0]   stat_stalls;
`endif

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PKT_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .empty      (empty),
        .rd_en      (rd_en),
        .r_data     (r_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef FIFO_READER_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_stalls(stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read FIFO model, depth 8.
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] f_mem [8];
    logic [3:0]    f_count;
    logic [2:0]    f_wp;
    logic [2:0]    f_rp;
    logic          f_wr;
    logic          f_rd;

    assign empty = (f_count == 4'd0);
    assign f_wr  = wr_en && (f_count != 4'd8);
    assign f_rd  = rd_en && !empty;

    always @(posedge clk) begin
        if (rst) begin
            f_count <= 4'd0;
            f_wp    <= 3'd0;
            f_rp    <= 3'd0;
            r_data  <= '0;
        end else begin
            if (f_wr) begin
                f_mem[f_wp] <= wr_data;
                f_wp        <= f_wp + 3'd1;
            end
            if (f_rd) begin
                r_data <= f_mem[f_rp];
                f_rp   <= f_rp + 3'd1;
            end
            f_count <= f_count + {3'b000, f_wr} - {3'b000, f_rd};
        end
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t sb[$];
    int   exp_idx;
    int   n_cmp;
    int   n_fail;
    int   cyc;
    int   rd_cnt;
    int   hs_cnt;
    int   stall_cnt;
    int   t_empty_fall;
    int   t_valid_rise;
    int   last_hs_cyc;
    logic prev_empty;
    logic prev_valid;
    logic          s_rd_en;
    logic          s_valid;
    logic          s_last;
    logic [DW-1:0] s_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        exp_t e;
        wr_en   = 1'b1;
        wr_data = d;
        e.d     = d;
        e.l     = ((exp_idx % PKT_LEN) == PKT_LEN - 1);
        sb.push_back(e);
        exp_idx++;
    endtask

    // One cycle: sample 1 time unit after the negedge (inputs already applied), then wait out the posedge.
    task automatic tick();
        exp_t e;
        #1;
        cyc++;
        s_rd_en = rd_en;
        s_valid = m_valid;
        s_data  = m_data;
        s_last  = m_last;
        if (prev_empty && !empty) t_empty_fall = cyc;
        if (!prev_valid && m_valid) t_valid_rise = cyc;
        prev_empty = empty;
        prev_valid = m_valid;
        if (rd_en) begin
            rd_cnt++;
            check("rd_while_empty", 32'(empty), 32'd0);
        end
        if (m_valid && !m_ready) stall_cnt++;
        if (m_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 32'(m_valid), 32'd0);
            end else begin
                e = sb[0];
                check("m_data", 32'(m_data), 32'(e.d));
                check("m_last", 32'(m_last), 32'(e.l));
                if (m_ready) begin
                    void'(sb.pop_front());
                    hs_cnt++;
                    last_hs_cyc = cyc;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        tick();
        tick();
        sb.delete();
        exp_idx = 0;
        rst     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hs0;
        int   rd0;
        int   st0;
        logic found;

        n_cmp = 0; n_fail = 0; cyc = 0; rd_cnt = 0; hs_cnt = 0; stall_cnt = 0;
        exp_idx = 0; t_empty_fall = -100; t_valid_rise = -100; last_hs_cyc = 0;
        prev_empty = 1'b1; prev_valid = 1'b0;
        rst = 1'b1; m_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
        @(negedge clk);

        // Reset state, then 10 idle cycles with the FIFO empty.
        tick();
        tick();
        check("rst_rd_en",   32'(s_rd_en), 32'd0);
        check("rst_m_valid", 32'(s_valid), 32'd0);
        check("rst_m_last",  32'(s_last),  32'd0);
        check("rst_m_data",  32'(s_data),  32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_rd_en",   32'(s_rd_en), 32'd0);
            check("idle_m_valid", 32'(s_valid), 32'd0);
            check("idle_m_last",  32'(s_last),  32'd0);
        end

        // Streaming 'h10..'h17 with m_ready high.
        m_ready = 1'b1;
        hs0 = hs_cnt;
        for (int i = 0; i < 8; i++) begin
            push_word(8'h10 + 8'(i));
            tick();
        end
        wr_en = 1'b0;
        drain(40);
        check("s1_words",       32'(hs_cnt - hs0), 32'd8);
        check("s1_drained",     32'(sb.size()), 32'd0);
        check("s1_latency",     32'(t_valid_rise - t_empty_fall), 32'd2);
        check("s1_consecutive", 32'(last_hs_cyc - t_valid_rise), 32'd7);

        // Backpressure: fill, hold m_ready low for 20 valid cycles, release.
        do_reset();
        m_ready = 1'b0;
        hs0 = hs_cnt; rd0 = rd_cnt; st0 = stall_cnt;
        for (int i = 0; i < 100; i++) begin
            if (stall_cnt - st0 >= 20) break;
            if (i < 8) push_word(8'h10 + 8'(i));
            else wr_en = 1'b0;
            tick();
        end
        wr_en = 1'b0;
        check("s2_stall_cycles", 32'(stall_cnt - st0), 32'd20);
        check("s2_reads_in_stall", 32'(rd_cnt - rd0), 32'd3);
        m_ready = 1'b1;
        tick();
        check("s2_rd_low_at_release", 32'(s_rd_en), 32'd0);
        tick();
        check("s2_rd_after_pop", 32'(s_rd_en), 32'd1);
        drain(60);
        check("s2_words",   32'(hs_cnt - hs0), 32'd8);
        check("s2_drained", 32'(sb.size()), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("s2_stat_words",  stat_words,  32'd8);
        check("s2_stat_stalls", stat_stalls, 32'd20);
`endif

        // m_ready toggling every cycle over 8 words.
        hs0 = hs_cnt;
        for (int i = 0; i < 100; i++) begin
            if (i >= 8 && sb.size() == 0) break;
            if (i < 8) push_word(8'h20 + 8'(i));
            else wr_en = 1'b0;
            m_ready = (i % 2 == 0);
            tick();
        end
        wr_en = 1'b0;
        check("s3_words",   32'(hs_cnt - hs0), 32'd8);
        check("s3_drained", 32'(sb.size()), 32'd0);

        // Mid-transfer reset with 2 words buffered, 1 in flight and pkt_cnt non-zero.
        hs0 = hs_cnt;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i < 6) push_word(8'h30 + 8'(i));
            else wr_en = 1'b0;
            m_ready = (hs_cnt == hs0);
            tick();
            if (!m_ready && s_valid && !s_rd_en) begin
                found = 1'b1;
                break;
            end
        end
        check("s4_reached_full", 32'(found), 32'd1);
        rst = 1'b1; wr_en = 1'b0; m_ready = 1'b0;
        tick();
        check("s4_rd_en_in_rst", 32'(s_rd_en), 32'd0);
        sb.delete();
        exp_idx = 0;
        rst = 1'b0;
        tick();
        check("s4_valid_after_rst", 32'(s_valid), 32'd0);
        check("s4_last_after_rst",  32'(s_last),  32'd0);
        tick();
        check("s4_inflight_dropped", 32'(s_valid), 32'd0);
        m_ready = 1'b1;
        hs0 = hs_cnt;
        for (int i = 0; i < 8; i++) begin
            push_word(8'h40 + 8'(i));
            tick();
        end
        wr_en = 1'b0;
        drain(40);
        check("s4_words",   32'(hs_cnt - hs0), 32'd8);
        check("s4_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
